clock_gen_multi: RTL and testbench

- Parametrised successor to the single-purpose game clock divider.
- Generates NUM_CH independent divided clocks from master_clk, each with a runtime-programmable half-period, an enable, and a one-cycle tick strobe, plus a free-running power-of-two pixel clock.
- Divisors are reprogrammed through a valid/ready config port. Updates take effect only at a channel's terminal count, so the output stays glitch-free.
- Feeds the game FSM (tick), the LED/segment blink logic (clk_out) and the VGA pipeline (clk_pixel).

---
 rtl/clock_gen_multi_if.sv | 14 +
 rtl/clock_gen_multi.sv | 105 ++++++++++
 tb/tb_clock_gen_multi.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/clock_gen_multi_if.sv
// Config port for clock_gen_multi: one {channel, divisor} request per valid/ready transfer.
// cfg_ready is registered in the slave and only ever stalls the master, never drops a request.
interface clock_gen_multi_if #(
    parameter int CTR_WIDTH = 28,
    parameter int CH_W      = 2
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_W-1:0]      cfg_ch;
    logic [CTR_WIDTH-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_gen_multi.sv
// NUM_CH programmable divided clocks with tick strobes plus a power-of-two pixel clock; outputs registered, 1-cycle latency.
// Config is a single pending slot: cfg_ready stays low until the update lands at the target's terminal count, disable or sync_clr.
module clock_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int CTR_WIDTH   = 28,
    parameter int DEFAULT_DIV = 100000,
    parameter int PIX_SHIFT   = 1,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              master_clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    clock_gen_multi_if.slave  cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              clk_pixel
);
    logic [CTR_WIDTH-1:0] r_ctr     [NUM_CH];
    logic [CTR_WIDTH-1:0] r_div     [NUM_CH];
    logic [CTR_WIDTH-1:0] w_ctr_nxt [NUM_CH];
    logic [CTR_WIDTH-1:0] w_div_nxt [NUM_CH];
    logic [NUM_CH-1:0]    r_clk, r_tick, w_clk_nxt, w_tick_nxt;
    logic [NUM_CH-1:0]    w_term, w_hit, w_apply;
    logic                 r_pend, w_pend_nxt, r_rdy, w_xfer;
    logic [CH_W-1:0]      r_pend_ch;
    logic [CTR_WIDTH-1:0] r_pend_div;
    // Only bit PIX_SHIFT is observable, so the higher counter bits are not kept.
    logic [PIX_SHIFT:0]   r_pix;

    assign w_xfer = cfg.cfg_valid && r_rdy;

    always_comb begin
        w_term     = '0;
        w_hit      = '0;
        w_apply    = '0;
        w_clk_nxt  = r_clk;
        w_tick_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ctr_nxt[i] = r_ctr[i];
            w_div_nxt[i] = r_div[i];
            w_term[i]    = (r_ctr[i] == r_div[i]);
            w_hit[i]     = (r_pend_ch == CH_W'(i));
            w_apply[i]   = r_pend && w_hit[i] && (w_term[i] || !ch_en[i] || sync_clr);
            if (sync_clr) begin
                w_ctr_nxt[i] = '0;
                w_clk_nxt[i] = 1'b0;
            end else if (ch_en[i]) begin
                if (w_term[i]) begin
                    w_ctr_nxt[i]  = '0;
                    w_clk_nxt[i]  = ~r_clk[i];
                    w_tick_nxt[i] = 1'b1;
                end else begin
                    w_ctr_nxt[i] = r_ctr[i] + CTR_WIDTH'(1);
                end
            end
            if (w_apply[i]) begin
                w_div_nxt[i] = r_pend_div;
                // A held count above the new terminal would never match again.
                if (!sync_clr && !ch_en[i] && (r_ctr[i] > r_pend_div))
                    w_ctr_nxt[i] = '0;
            end
        end
        w_pend_nxt = r_pend;
        if (r_pend && ((|w_apply) || !(|w_hit)))
            w_pend_nxt = 1'b0;
        if (w_xfer)
            w_pend_nxt = 1'b1;
    end

    always_ff @(posedge master_clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ctr[i] <= '0;
                r_div[i] <= CTR_WIDTH'(DEFAULT_DIV);
            end
            r_clk      <= '0;
            r_tick     <= '0;
            r_pend     <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_div <= '0;
            r_rdy      <= 1'b0;
            r_pix      <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ctr[i] <= w_ctr_nxt[i];
                r_div[i] <= w_div_nxt[i];
            end
            r_clk  <= w_clk_nxt;
            r_tick <= w_tick_nxt;
            r_pend <= w_pend_nxt;
            r_rdy  <= !w_pend_nxt;
            r_pix  <= r_pix + (PIX_SHIFT+1)'(1);
            if (w_xfer) begin
                r_pend_ch  <= cfg.cfg_ch;
                r_pend_div <= cfg.cfg_div;
            end
        end
    end

    assign cfg.cfg_ready = r_rdy;
    assign clk_out       = r_clk;
    assign tick          = r_tick;
    assign clk_pixel     = r_pix[PIX_SHIFT];
endmodule

// File: tb/tb_clock_gen_multi.sv
// Bench for clock_gen_multi with NUM_CH=2, DEFAULT_DIV=3, PIX_SHIFT=1; hand-derived vectors fed through a scoreboard queue.
module tb_clock_gen_multi;
    logic       master_clk = 1'b0;
    logic       rst;
    logic [1:0] ch_en;
    logic       sync_clr;
    logic [1:0] clk_out, tick;
    logic       clk_pixel;

    clock_gen_multi_if #(.CTR_WIDTH(28), .CH_W(2)) cfg_if ();

    clock_gen_multi #(
        .NUM_CH(2), .CTR_WIDTH(28), .DEFAULT_DIV(3), .PIX_SHIFT(1), .CH_W(2)
    ) dut (
        .master_clk(master_clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync_clr  (sync_clr),
        .cfg       (cfg_if.slave),
        .clk_out   (clk_out),
        .tick      (tick),
        .clk_pixel (clk_pixel)
    );

    always #5 master_clk = ~master_clk;

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic       clr;
        logic       vld;
        logic [1:0] ch;
        logic [7:0] dv;
        logic [1:0] eclk;
        logic [1:0] etick;
        logic       erdy;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[14];
    int   errors  = 0;
    int   checks  = 0;
    int   rel_cyc = 0;
    int   edge_no = 0;

    function automatic vec_t mk(input logic r, input logic [1:0] en, input logic clr,
                                input logic vld, input logic [1:0] ch, input logic [7:0] dv,
                                input logic [1:0] ec, input logic [1:0] et, input logic er);
        vec_t v;
        v.rst = r; v.en = en; v.clr = clr; v.vld = vld; v.ch = ch; v.dv = dv;
        v.eclk = ec; v.etick = et; v.erdy = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, edge_no, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        vec_t e;
        rst              = v.rst;
        ch_en            = v.en;
        sync_clr         = v.clr;
        cfg_if.cfg_valid = v.vld;
        cfg_if.cfg_ch    = v.ch;
        cfg_if.cfg_div   = 28'(v.dv);
        sb.push_back(v);
        @(posedge master_clk);
        #1;
        edge_no++;
        if (v.rst) rel_cyc++;
        else       rel_cyc = 0;
        e = sb.pop_front();
        chk("clk_out",   {2'b00, clk_out},          {2'b00, e.eclk});
        chk("tick",      {2'b00, tick},             {2'b00, e.etick});
        chk("cfg_ready", {3'b000, cfg_if.cfg_ready}, {3'b000, e.erdy});
        chk("clk_pixel", {3'b000, clk_pixel},       {3'b000, 1'((rel_cyc >> 1) & 1)});
    endtask

    task automatic run(input logic r, input logic [1:0] en, input logic clr, input logic vld,
                       input logic [1:0] ch, input logic [7:0] dv,
                       input logic [1:0] ec, input logic [1:0] et, input logic er);
        apply_vec(mk(r, en, clr, vld, ch, dv, ec, et, er));
    endtask

    initial begin
        rst = 1'b0; ch_en = 2'b00; sync_clr = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_div = 28'd0;
        #1;

        // reset, then both channels at default divisor 3
        tbl[0]  = mk(0, 2'b00, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 0);
        tbl[1]  = mk(0, 2'b00, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 0);
        tbl[2]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        tbl[3]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        tbl[4]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        tbl[5]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b11, 1);
        tbl[6]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        tbl[7]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        tbl[8]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        tbl[9]  = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b11, 1);
        tbl[10] = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        tbl[11] = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        tbl[12] = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        tbl[13] = mk(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b11, 1);
        for (int i = 0; i < 14; i++) apply_vec(tbl[i]);

        // ch0 -> div 1 requested at ctr=1; lands at its terminal two edges later
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        run(1, 2'b11, 0, 1, 2'd0, 8'd1, 2'b11, 2'b00, 0);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 0);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b11, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b01, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b10, 2'b11, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b10, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b01, 1);

        // ch1 frozen at ctr=2 for 10 cycles while ch0 keeps its 2-cycle tick
        for (int k = 0; k < 10; k++)
            run(1, 2'b01, 0, 0, 2'd0, 8'd0, {1'b1, 1'((k % 4) == 0 || (k % 4) == 3)},
                {1'b0, 1'(k % 2)}, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b10, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b11, 1);

        // ch1 at ctr=3 disabled and set to div 0
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b01, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        run(1, 2'b01, 0, 1, 2'd1, 8'd0, 2'b01, 2'b01, 0);
        run(1, 2'b01, 0, 0, 2'd0, 8'd0, 2'b01, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b10, 2'b11, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b10, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b11, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b10, 1);

        // request to nonexistent channel 3, then sync_clr; then clr together with a transfer
        run(1, 2'b11, 0, 1, 2'd3, 8'd5, 2'b10, 2'b11, 0);
        run(1, 2'b11, 1, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        run(1, 2'b11, 1, 1, 2'd0, 8'd3, 2'b00, 2'b00, 0);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b10, 2'b10, 0);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b11, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b10, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b01, 2'b10, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b10, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b11, 1);

        // reset with an update pending; defaults must return and the update is lost
        run(1, 2'b11, 0, 1, 2'd1, 8'd7, 2'b10, 2'b10, 0);
        run(0, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 0);
        run(0, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 0);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b11, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b11, 2'b00, 1);
        run(1, 2'b11, 0, 0, 2'd0, 8'd0, 2'b00, 2'b11, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
